switch_step_debouncer: RTL and testbench
========================================

# switch_step_debouncer

Upstream conditioning stage for the lab sequence-detector comparison. It turns the raw step push-button and raw data switch into clean signals in the 50 MHz domain. Each confirmed button press produces a single one-cycle `step` strobe, and the data bit is sampled at that instant and held, so both detector FSMs see exactly one clean, glitch-free advance per press. The block also keeps a wrapping press counter for board display.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: stable cycles required to accept a press or a release (20 ms at 50 MHz). Minimum 2.
- `REPEAT_CYCLES`, default 25_000_000: auto-repeat period while held (0.5 s). Must be ≥ `DEBOUNCE_CYCLES`.
- `CNT_W`, default 25: width of the shared cycle counter. Must hold `max(DEBOUNCE_CYCLES, REPEAT_CYCLES)-1`.
- `CLK` in 1: 50 MHz board clock; all state changes on the rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `raw_btn` in 1: raw step push-button, asynchronous and bouncy; 1 = pressed.
- `A_raw` in 1: raw data switch, asynchronous.
- `step` out 1: one-cycle strobe per accepted press, or per auto-repeat.
- `A_step` out 1: synchronized `A_raw`, captured on each `step` and held between steps.
- `btn_db` out 1: debounced button level.
- `step_count` out 8: number of `step` strobes, modulo 256.

## Operation
- **Synchronizers.** `raw_btn` and `A_raw` each pass through a 2-FF synchronizer. The FSM reads only `btn_s` and `A_s`.
- **Counter.** A single counter `cnt` of width `CNT_W` is cleared on every state change.
- **FSM states:**
  - **IDLE** (`btn_db`=0): if `btn_s`=1, go to PRESS_CHK.
  - **PRESS_CHK** (`btn_db`=0):
    - `btn_s`=0: return to IDLE.
    - `btn_s`=1 and `cnt`==`DEBOUNCE_CYCLES-1`: go to HELD and assert `step`.
    - Otherwise `cnt`++.
  - **HELD** (`btn_db`=1):
    - `btn_s`=0: go to RELEASE_CHK.
    - Otherwise the auto-repeat behaviour applies (see Configuration).
  - **RELEASE_CHK** (`btn_db`=1):
    - `btn_s`=1: return to HELD with `cnt` cleared; no `step`.
    - `btn_s`=0 and `cnt`==`DEBOUNCE_CYCLES-1`: go to IDLE.
    - Otherwise `cnt`++.
- **Registered outputs.** `step`, `btn_db`, `A_step` and `step_count` are all registered.
- **On each `step` edge:**
  - `A_step` is loaded from `A_s`.
  - `step_count` is incremented, wrapping 0xFF → 0x00.
- **Between steps.** `A_step` ignores any change on `A_raw`.
- **Release.** A release never produces `step`.
- **Reset mid-operation.** Any state returns to IDLE. A button still held after reset deasserts must complete a full PRESS_CHK before any `step`.

## Timing
- **Reset values.** `step`=0, `btn_db`=0, `A_step`=0, `step_count`=0x00, state IDLE, `cnt`=0, all synchronizer flops 0.
- **Press latency.** `raw_btn` is first sampled high at edge k and stays stable. PRESS_CHK is entered at edge k+2. `step` and `btn_db` rise at edge k+2+`DEBOUNCE_CYCLES`, and `step` falls one edge later.
- **Release latency.** `raw_btn` is first sampled low at edge r and stays stable. `btn_db` falls at edge r+2+`DEBOUNCE_CYCLES`.
- **Strobe width.** `step` is never high for two consecutive cycles.
- **Simultaneous events.** If `A_raw` changes in the same cycle the press is accepted, `A_step` takes the value of `A_s` at that edge; this is 2-cycle-delayed data, by design.

## Configuration
- **Macro:** `SWITCH_STEP_AUTOREPEAT_EN`.
- **Defined:** in HELD with `btn_s`=1:
  - `cnt` increments each edge.
  - When `cnt`==`REPEAT_CYCLES-1`, `step` is asserted, `A_step` and `step_count` update, and `cnt` is cleared.
  - The first repeat occurs `REPEAT_CYCLES` edges after entering HELD.
  - A return from RELEASE_CHK to HELD restarts the repeat period.
- **Not defined:** HELD holds `cnt` at 0 and produces exactly one `step` per press. `REPEAT_CYCLES` is unused.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_CYCLES`=10.
1. **Reset.** Assert `RESET_N`=0 asynchronously mid-cycle → `step`=0, `btn_db`=0, `A_step`=0 and `step_count`=0x00 immediately, before the next edge.
2. **Clean press.** `raw_btn` sampled high at edge k, held 20 cycles, then released → `step` high only in the cycle after edge k+6; `btn_db` rises at k+6; `step_count`=1; `btn_db` falls 6 edges after release; no second `step`.
3. **Bounce.** Pattern `raw_btn` = 1,1,1,0 repeated 5×, then a stable 1 → exactly one `step`, 6 edges after the final stable rise; `step_count`=1.
4. **Data capture.** `A_raw`=1 for 10 cycles before the press, then toggled every cycle while held → `A_step`=1 from the `step` edge and unchanged until the next press.
5. **Reset and wrap.**
   - `RESET_N` pulsed low in PRESS_CHK with the button held → no `step`; after reset, `step` arrives 6 edges after deassertion.
   - 256 clean presses → `step_count` returns to 0x00.
6. **Auto-repeat.** Hold for 40 cycles after entering HELD:
   - With `SWITCH_STEP_AUTOREPEAT_EN` → `step` at HELD+10, +20, +30, +40; `step_count`=5.
   - Without the macro → a single `step`; `step_count`=1.

Source files
------------

// File: rtl/switch_step_debouncer.sv
// ============================================================================
//  Module      : switch_step_debouncer
//  Description : Synchronizes and debounces the step push-button and data
//                switch; emits one clean step strobe per press, samples the
//                data bit on that strobe and counts strobes for display.
//                Optional auto-repeat while held: SWITCH_STEP_AUTOREPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_step_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_CYCLES   = 25_000_000,
    parameter int CNT_W           = 25
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       raw_btn,
    input  logic       A_raw,
    output logic       step,
    output logic       A_step,
    output logic       btn_db,
    output logic [7:0] step_count
);

    localparam logic [CNT_W-1:0] c_db_last  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_rep_last = CNT_W'(REPEAT_CYCLES - 1);
    // Ceiling of the shared counter; it never needs to run past the longer period.
    localparam logic [CNT_W-1:0] c_cnt_max  =
        (REPEAT_CYCLES > DEBOUNCE_CYCLES) ? c_rep_last : c_db_last;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_PRESS_CHK   = 2'd1,
        S_HELD        = 2'd2,
        S_RELEASE_CHK = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_fire;

    logic r_btn_meta, r_btn_s;
    logic r_a_meta,   r_a_s;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_btn_meta <= 1'b0;
            r_btn_s    <= 1'b0;
            r_a_meta   <= 1'b0;
            r_a_s      <= 1'b0;
        end else begin
            r_btn_meta <= raw_btn;
            r_btn_s    <= r_btn_meta;
            r_a_meta   <= A_raw;
            r_a_s      <= r_a_meta;
        end
    end

    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fire      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_btn_s) begin
                    w_state_nxt = S_PRESS_CHK;
                    w_cnt_nxt   = '0;
                end
            end
            S_PRESS_CHK: begin
                if (!r_btn_s) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_db_last) begin
                    w_state_nxt = S_HELD;
                    w_cnt_nxt   = '0;
                    w_fire      = 1'b1;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            S_HELD: begin
                if (!r_btn_s) begin
                    w_state_nxt = S_RELEASE_CHK;
                    w_cnt_nxt   = '0;
                end else begin
`ifdef SWITCH_STEP_AUTOREPEAT_EN
                    if (r_cnt == c_rep_last) begin
                        w_cnt_nxt = '0;
                        w_fire    = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
`else
                    w_cnt_nxt = '0;
`endif
                end
            end
            S_RELEASE_CHK: begin
                // A bounce back to pressed re-enters HELD silently.
                if (r_btn_s) begin
                    w_state_nxt = S_HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_db_last) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            step       <= 1'b0;
            btn_db     <= 1'b0;
            A_step     <= 1'b0;
            step_count <= 8'h00;
        end else begin
            step   <= w_fire;
            btn_db <= (w_state_nxt == S_HELD) || (w_state_nxt == S_RELEASE_CHK);
            if (w_fire) begin
                A_step     <= r_a_s;
                step_count <= step_count + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_switch_step_debouncer.sv
// ============================================================================
//  Module      : tb_switch_step_debouncer
//  Description : Scoreboard bench for switch_step_debouncer with a run-length
//                reference model of the debounce/auto-repeat behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_step_debouncer;

    localparam int D = 4;
    localparam int R = 10;
`ifdef SWITCH_STEP_AUTOREPEAT_EN
    localparam int EXP_T2 = 2;
    localparam int EXP_T6 = 5;
`else
    localparam int EXP_T2 = 1;
    localparam int EXP_T6 = 1;
`endif

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b1;
    logic       raw_btn = 1'b0;
    logic       A_raw = 1'b0;
    logic       step;
    logic       A_step;
    logic       btn_db;
    logic [7:0] step_count;

    switch_step_debouncer #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_CYCLES  (R),
        .CNT_W          (5)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .raw_btn   (raw_btn),
        .A_raw     (A_raw),
        .step      (step),
        .A_step    (A_step),
        .btn_db    (btn_db),
        .step_count(step_count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       a;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;
    logic mon_en = 1'b0;

    // Reference model: debounced level flips after D+1 consecutive
    // disagreeing samples of the twice-delayed button.
    logic       m_lvl, m_bd1, m_bd2, m_ad1, m_ad2, m_astep;
    int         m_run;
    logic [7:0] m_cnt;
`ifdef SWITCH_STEP_AUTOREPEAT_EN
    int         m_hold;
    logic       m_broken;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lvl = 0; m_bd1 = 0; m_bd2 = 0; m_ad1 = 0; m_ad2 = 0;
        m_astep = 0; m_run = 0; m_cnt = 8'h00;
`ifdef SWITCH_STEP_AUTOREPEAT_EN
        m_hold = 0; m_broken = 0;
`endif
        q.delete();
    endtask

    task automatic model_edge(input logic b, input logic a);
        logic bs, as_, fire;
        bs = m_bd2; as_ = m_ad2;
        m_bd2 = m_bd1; m_bd1 = b;
        m_ad2 = m_ad1; m_ad1 = a;
        fire = 1'b0;
        if (bs != m_lvl) begin
            m_run++;
            if (m_run == D + 1) begin
                m_lvl = bs;
                m_run = 0;
                fire  = bs;
`ifdef SWITCH_STEP_AUTOREPEAT_EN
                m_hold = 0; m_broken = 0;
`endif
            end
        end else begin
            m_run = 0;
        end
`ifdef SWITCH_STEP_AUTOREPEAT_EN
        if (m_lvl && !fire) begin
            if (!bs) m_broken = 1;
            else if (m_broken) begin m_broken = 0; m_hold = 0; end
            else begin
                m_hold++;
                if (m_hold == R) begin fire = 1'b1; m_hold = 0; end
            end
        end
`endif
        if (fire) begin
            m_cnt   = m_cnt + 8'd1;
            m_astep = as_;
            q.push_back('{a: as_, cnt: m_cnt});
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick(input logic b, input logic a);
        raw_btn = b;
        A_raw   = a;
        @(posedge CLK);
        model_edge(b, a);
        @(negedge CLK);
    endtask

    task automatic reset_pulse();
        #2 RESET_N = 1'b0;
        #1;
        chk("rst_step",   step,       0);
        chk("rst_btn_db", btn_db,     0);
        chk("rst_A_step", A_step,     0);
        chk("rst_count",  step_count, 0);
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    // Monitor: pops one expectation per observed strobe, tracks levels every cycle.
    initial begin
        exp_t e;
        wait (mon_en);
        forever begin
            @(negedge CLK);
            if (step || q.size() != 0) begin
                chk("step_strobe", step, (q.size() != 0));
                if (q.size() != 0) begin
                    e = q.pop_front();
                    if (step) begin
                        chk("A_step_at_step", A_step, e.a);
                        chk("count_at_step", step_count, e.cnt);
                    end
                end
            end
            chk("btn_db",     btn_db,     m_lvl);
            chk("A_step_hold", A_step,    m_astep);
            chk("step_count", step_count, m_cnt);
        end
    end

    initial begin
        model_reset();
        @(negedge CLK);
        reset_pulse();
        mon_en = 1'b1;

        // Clean press: step and btn_db at k+6, release falls 6 edges later.
        reset_pulse();
        repeat (6) tick(1, 0);
        chk("t2_db_k5", btn_db, 0);
        chk("t2_step_k5", step, 0);
        tick(1, 0);
        chk("t2_step_k6", step, 1);
        chk("t2_db_k6", btn_db, 1);
        tick(1, 0);
        chk("t2_step_k7", step, 0);
        repeat (12) tick(1, 0);
        repeat (6) tick(0, 0);
        chk("t2_db_r5", btn_db, 1);
        tick(0, 0);
        chk("t2_db_r6", btn_db, 0);
        repeat (3) tick(0, 0);
        chk("t2_count", step_count, EXP_T2);

        // Bounce 1,1,1,0 x5 then stable high.
        reset_pulse();
        repeat (5) begin tick(1, 0); tick(1, 0); tick(1, 0); tick(0, 0); end
        repeat (6) tick(1, 0);
        chk("t3_count_pre", step_count, 0);
        tick(1, 0);
        chk("t3_step", step, 1);
        chk("t3_count", step_count, 1);
        repeat (8) tick(0, 0);

        // Data capture: A held high through acceptance, then toggled.
        reset_pulse();
        repeat (10) tick(0, 1);
        repeat (7) tick(1, 1);
        chk("t4_A_step", A_step, 1);
        for (int i = 0; i < 6; i++) tick(1, 1'(i & 1));
        for (int i = 0; i < 10; i++) tick(0, 1'(i & 1));
        chk("t4_A_hold", A_step, 1);
        chk("t4_count", step_count, 1);

        // Reset during PRESS_CHK with the button still held.
        reset_pulse();
        repeat (4) tick(1, 0);
        reset_pulse();
        repeat (6) tick(1, 0);
        chk("t5_count_pre", step_count, 0);
        tick(1, 0);
        chk("t5_step", step, 1);
        repeat (8) tick(0, 0);

        // 256 clean presses wrap the counter.
        reset_pulse();
        repeat (256) begin
            repeat (8) tick(1, 0);
            repeat (8) tick(0, 0);
        end
        chk("t5_wrap", step_count, 0);

        // Held 40 cycles after entering HELD.
        reset_pulse();
        repeat (7) tick(1, 0);
        repeat (40) tick(1, 0);
        chk("t6_count_held", step_count, EXP_T6);
        repeat (10) tick(0, 0);
        chk("t6_count_rel", step_count, EXP_T6);

        // Randomized runs with random data and occasional resets.
        for (int r = 0; r < 160; r++) begin
            int len;
            len = int'($urandom_range(1, (r % 7 == 0) ? 30 : 12));
            for (int j = 0; j < len; j++) tick(1'(r & 1), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 39) == 0) reset_pulse();
        end
        repeat (12) tick(0, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

`default_nettype wire
